// File: rtl/rle_encoder.sv
// rle_encoder - run-length encoder with bypass mode and a small output queue
// Emits {sample, count} word pairs into a push-only FIFO interface.
module rle_encoder #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    rle_en,
  input  logic                    flush,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic                    valid_in,
  output logic [SAMPLE_WIDTH-1:0] data_out,
  output logic                    valid_out,
  output logic                    busy,
  output logic                    overflow
);

  localparam int W  = SAMPLE_WIDTH;
  localparam int CW = W - 1;
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [CW-1:0] MAX_CNT = '1;
  localparam logic [AW:0]   DEPTH   = (AW+1)'(QUEUE_DEPTH);

  logic [CW-1:0] last_q, last_d;
  logic          have_last_q, have_last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mem_q [QUEUE_DEPTH];
  logic [W-1:0]  mem_d [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   qcnt_q, qcnt_d;
  logic [W-1:0]  data_out_q, data_out_d;
  logic          valid_out_q, valid_out_d;
  logic          overflow_q, overflow_d;

  logic [CW-1:0] s;
  logic [1:0]    push_n, enq_n;
  logic [W-1:0]  push0, push1, enq0, enq1;
  logic          pop_q;
  logic [AW:0]   free, enq_w, wr_n;

  // Up to two words per cycle: the result of valid_in, then the flush count.
  always_comb begin
    s           = data_in[CW-1:0];
    last_d      = last_q;
    have_last_d = have_last_q;
    cnt_d       = cnt_q;
    push_n      = 2'd0;
    push0       = '0;
    push1       = '0;
    if (valid_in) begin
      if (!rle_en) begin
        push_n = 2'd1;
        push0  = data_in;
      end else if (!have_last_q) begin
        push_n      = 2'd1;
        push0       = {1'b0, s};
        last_d      = s;
        have_last_d = 1'b1;
        cnt_d       = '0;
      end else if (s == last_q) begin
        if (cnt_q != MAX_CNT) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          push_n = 2'd1;
          push0  = {1'b1, MAX_CNT};
          cnt_d  = CW'(1);
        end
      end else begin
        if (cnt_q != '0) begin
          push_n = 2'd2;
          push0  = {1'b1, cnt_q};
          push1  = {1'b0, s};
        end else begin
          push_n = 2'd1;
          push0  = {1'b0, s};
        end
        last_d = s;
        cnt_d  = '0;
      end
    end
    if (flush) begin
      if (cnt_d != '0) begin
        if (push_n == 2'd0) push0 = {1'b1, cnt_d};
        else                push1 = {1'b1, cnt_d};
        push_n = push_n + 2'd1;
      end
      cnt_d       = '0;
      have_last_d = 1'b0;
    end
    if (clear) begin
      last_d      = '0;
      have_last_d = 1'b0;
      cnt_d       = '0;
    end
  end

  // An empty queue lets the first new word go straight to data_out.
  always_comb begin
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    overflow_d  = overflow_q;
    valid_out_d = 1'b0;
    data_out_d  = data_out_q;
    enq_n       = 2'd0;
    enq0        = '0;
    enq1        = '0;
    pop_q       = (qcnt_q != '0);
    if (pop_q) begin
      valid_out_d = 1'b1;
      data_out_d  = mem_q[rd_ptr_q];
      rd_ptr_d    = rd_ptr_q + 1'b1;
      enq_n       = push_n;
      enq0        = push0;
      enq1        = push1;
    end else if (push_n != 2'd0) begin
      valid_out_d = 1'b1;
      data_out_d  = push0;
      enq_n       = push_n - 2'd1;
      enq0        = push1;
    end
    free  = DEPTH - qcnt_q + {{AW{1'b0}}, pop_q};
    enq_w = {{(AW-1){1'b0}}, enq_n};
    if (enq_w > free) begin
      overflow_d = 1'b1;
      wr_n       = free;
    end else begin
      wr_n = enq_w;
    end
    if (wr_n >= (AW+1)'(1)) mem_d[wr_ptr_q] = enq0;
    if (wr_n >= (AW+1)'(2)) mem_d[AW'(wr_ptr_q + 1'b1)] = enq1;
    wr_ptr_d = wr_ptr_q + wr_n[AW-1:0];
    qcnt_d   = qcnt_q - {{AW{1'b0}}, pop_q} + wr_n;
    if (clear) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      qcnt_d      = '0;
      overflow_d  = 1'b0;
      valid_out_d = 1'b0;
      data_out_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q      <= '0;
      have_last_q <= 1'b0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      qcnt_q      <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      last_q      <= last_d;
      have_last_q <= have_last_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      qcnt_q      <= qcnt_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
    end
  end

  // Queue storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign overflow  = overflow_q;
  assign busy      = (qcnt_q != '0) | valid_out_q | (cnt_q != '0);

endmodule

// File: tb/tb_rle_encoder.sv
// tb/tb_rle_encoder.sv - directed self-checking bench for rle_encoder
// Output words are captured on the falling edge together with their cycle number.
module tb_rle_encoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       rle_en = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, busy, overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] got[$];
  int         got_cyc[$];

  rle_encoder #(.SAMPLE_WIDTH(8), .QUEUE_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .clear(clear), .rle_en(rle_en), .flush(flush),
    .data_in(data_in), .valid_in(valid_in), .data_out(data_out),
    .valid_out(valid_out), .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (valid_out) begin
    got.push_back(data_out);
    got_cyc.push_back(cyc);
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic f);
    valid_in = v; data_in = d; flush = f;
    @(posedge clock); #1;
    valid_in = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic test_reset;
    #1;
    checks += 4;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h exp 00", data_out); end
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got %b exp 0", valid_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    @(posedge clock); #1; reset = 1'b0;
    idle(2);
  endtask

  task automatic test_bypass;
    logic [7:0] exp[3] = '{8'hA5, 8'hA5, 8'h3C};
    int in_c[3];
    rle_en = 1'b0; got.delete(); got_cyc.delete();
    for (int i = 0; i < 3; i++) begin in_c[i] = cyc; drive(1'b1, exp[i], 1'b0); end
    idle(4);
    checks++;
    if (got.size() != 3) begin errors++; $display("FAIL bypass_count got %0d exp 3", got.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks += 2;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL bypass_word%0d got %h exp %h", i, got[i], exp[i]); end
      if (got_cyc[i] != in_c[i] + 1) begin errors++; $display("FAIL bypass_latency%0d got %0d exp 1", i, got_cyc[i] - in_c[i]); end
    end
  endtask

  task automatic test_run;
    logic [7:0] exp[3] = '{8'h05, 8'h84, 8'h06};
    rle_en = 1'b1; got.delete();
    repeat (5) drive(1'b1, 8'h05, 1'b0);
    drive(1'b1, 8'h06, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    idle(4);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL run_busy got %b exp 0", busy); end
    if (got.size() != 3) begin errors++; $display("FAIL run_count got %0d exp 3", got.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL run_word%0d got %h exp %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_saturation;
    logic [7:0] exp[3] = '{8'h11, 8'hFF, 8'h82};
    got.delete();
    repeat (130) drive(1'b1, 8'h11, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    idle(4);
    checks++;
    if (got.size() != 3) begin errors++; $display("FAIL sat_count got %0d exp 3", got.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin errors++; $display("FAIL sat_word%0d got %h exp %h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] src[$];
    logic [7:0] dec[$];
    logic [7:0] lastw;
    lastw = 8'h00;
    got.delete();
    for (int i = 0; i < 32; i++) begin
      logic [7:0] v;
      v = 8'((i * 37 + 1) & 8'h7F);
      src.push_back(v); src.push_back(v);
    end
    foreach (src[i]) drive(1'b1, src[i], (i == 63) ? 1'b1 : 1'b0);
    idle(6);
    foreach (got[i]) begin
      if (got[i][7]) repeat (int'(got[i][6:0])) dec.push_back(lastw);
      else begin lastw = got[i]; dec.push_back(lastw); end
    end
    checks += 3;
    if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b exp 0", overflow); end
    if (got.size() != 64) begin errors++; $display("FAIL b2b_words got %0d exp 64", got.size()); end
    if (dec.size() != 64) begin errors++; $display("FAIL b2b_decoded_len got %0d exp 64", dec.size()); end
    else for (int i = 0; i < 64; i++) if (dec[i] !== src[i]) begin
      errors++; $display("FAIL b2b_decoded%0d got %h exp %h", i, dec[i], src[i]);
    end
  endtask

  task automatic test_flush_same_cycle;
    logic [7:0] exp_a[3] = '{8'h03, 8'h82, 8'h04};
    logic [7:0] exp_b[2] = '{8'h03, 8'h83};
    got.delete();
    repeat (3) drive(1'b1, 8'h03, 1'b0);
    drive(1'b1, 8'h04, 1'b1);
    idle(4);
    checks++;
    if (got.size() != 3) begin errors++; $display("FAIL flush_a_count got %0d exp 3", got.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (got[i] !== exp_a[i]) begin errors++; $display("FAIL flush_a_word%0d got %h exp %h", i, got[i], exp_a[i]); end
    end
    got.delete();
    repeat (3) drive(1'b1, 8'h03, 1'b0);
    drive(1'b1, 8'h03, 1'b1);
    idle(4);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_b_busy got %b exp 0", busy); end
    if (got.size() != 2) begin errors++; $display("FAIL flush_b_count got %0d exp 2", got.size()); end
    else for (int i = 0; i < 2; i++) begin
      checks++;
      if (got[i] !== exp_b[i]) begin errors++; $display("FAIL flush_b_word%0d got %h exp %h", i, got[i], exp_b[i]); end
    end
  endtask

  task automatic test_clear;
    got.delete();
    drive(1'b1, 8'h07, 1'b0);
    drive(1'b1, 8'h07, 1'b0);
    clear = 1'b1;
    drive(1'b1, 8'h09, 1'b1);
    clear = 1'b0;
    idle(3);
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy got %b exp 0", busy); end
    if (got.size() != 1) begin errors++; $display("FAIL clear_count got %0d exp 1", got.size()); end
    else if (got[0] !== 8'h07) begin errors++; $display("FAIL clear_word got %h exp 07", got[0]); end
    if (data_out !== 8'h00) begin errors++; $display("FAIL clear_data_out got %h exp 00", data_out); end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 8'h05, 1'b0);
    drive(1'b1, 8'h05, 1'b0);
    drive(1'b1, 8'h06, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    reset = 1'b1; #1;
    checks += 3;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid_out got %b exp 0", valid_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data_out got %h exp 00", data_out); end
    @(posedge clock); #1; reset = 1'b0;
    got.delete();
    idle(5);
    checks++;
    if (got.size() != 0) begin errors++; $display("FAIL mid_stale got %0d words exp 0", got.size()); end
    drive(1'b1, 8'h80, 1'b0);
    idle(2);
    checks++;
    if (got.size() != 1 || got[0] !== 8'h00) begin
      errors++; $display("FAIL msb_mask got %0d words first %h exp 1 word 00", got.size(), (got.size() > 0) ? got[0] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_run();
    test_saturation();
    test_back_to_back();
    test_flush_same_cycle();
    test_clear();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
